// File: rtl/display_scan_ctrl.sv
// Mode register and 4/5-slot time multiplexer for a shared active-low 7-segment bus.
// Optional build macro BLINK_EN: blanks digits 0/1 on alternate frame groups in set mode.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned BLINK_SHIFT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn,
  input  logic [27:0] digits_i,
  input  logic [6:0]  ap_seg_i,
  output logic [1:0]  mode,
  output logic [4:0]  an,
  output logic [6:0]  seg,
  output logic        slot_strobe
);

  localparam logic [1:0]       MODE_12H  = 2'b01;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       slot;
  logic [2:0]       slot_next;
  logic             cnt_last;
  logic [4:0]       an_d;
  logic [6:0]       seg_d;

  assign cnt_last = (cnt == CNT_LAST);

  // Slot 4 only follows slot 3 in 12h mode; a slot 4 orphaned by a mode change still returns to 0.
  always_comb begin
    slot_next = slot + 3'd1;
    if (slot == 3'd3 && mode != MODE_12H) begin
      slot_next = '0;
    end else if (slot >= 3'd4) begin
      slot_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= '0;
      btn_q       <= 1'b0;
      cnt         <= '0;
      slot        <= '0;
      slot_strobe <= 1'b0;
    end else begin
      btn_q       <= mode_btn;
      slot_strobe <= cnt_last;
      if (mode_btn && !btn_q) begin
        mode <= mode + 2'd1;
      end
      if (cnt_last) begin
        cnt  <= '0;
        slot <= slot_next;
      end else begin
        cnt  <= cnt + CNT_ONE;
      end
    end
  end

`ifdef BLINK_EN
  localparam int unsigned        FRAME_W  = BLINK_SHIFT + 1;
  localparam logic [1:0]         MODE_SET = 2'b10;
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  logic [FRAME_W-1:0] frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
    end else if (cnt_last && slot_next == 3'd0) begin
      frame <= frame + FRAME_ONE;
    end
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = '1;
    if (cnt >= CNT_BLANK) begin
      case (slot)
        3'd0: begin an_d = 5'b11110; seg_d = digits_i[6:0];   end
        3'd1: begin an_d = 5'b11101; seg_d = digits_i[13:7];  end
        3'd2: begin an_d = 5'b11011; seg_d = digits_i[20:14]; end
        3'd3: begin an_d = 5'b10111; seg_d = digits_i[27:21]; end
        3'd4: begin
          if (mode == MODE_12H) begin
            an_d  = 5'b01111;
            seg_d = ap_seg_i;
          end
        end
        default: ;
      endcase
`ifdef BLINK_EN
      if (mode == MODE_SET && frame[BLINK_SHIFT] && slot < 3'd2) begin
        an_d  = '1;
        seg_d = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule
